// File: rtl/ram_writer_pkg.sv
// ram_writer_pkg
// Shared definitions for the stream-to-RAM burst writer:
//   - default word width and memory depth
//   - FSM state encoding used by ram_stream_writer
package ram_writer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_dp.sv
// ram_dp
// Simple dual-port RAM: one synchronous write port and one registered
// read port. The array itself is never reset, so contents survive rst_n.
// The read register is reset so the visible output starts at zero.
// Ports:
//   clk      - clock, all activity on posedge
//   rst_n    - asynchronous active-low reset (read register only)
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - read data, one cycle after i_raddr (read-first on collision)
module ram_dp
  import ram_writer_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-blocking read of the array samples the pre-write contents, so a
  // same-address read/write returns the old word (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_stream_writer.sv
// ram_stream_writer
// Accepts a start request with a base address and a word count, then
// writes that many words from a valid-qualified input stream into a RAM
// at consecutive (wrapping) addresses. A separate read port gives
// registered access to the memory at any time.
// Ports:
//   clk        - clock, all logic on posedge
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle burst request (honoured only when idle)
//   base_addr  - first write address, sampled with start
//   len        - burst length 0..DEPTH, sampled with start
//   data_in    - stream write data
//   valid_in   - data_in qualifier
//   ready_out  - high while the burst is accepting words
//   busy       - high while a burst is in progress (WRITE or DONE)
//   done       - one-cycle pulse when the burst completes
//   addr_rd    - read address
//   data_out   - registered read data, one-cycle latency
module ram_stream_writer
  import ram_writer_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int DEPTH     = DEF_DEPTH,
  localparam int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DEPTH_LOG-1:0] base_addr,
  input  logic [DEPTH_LOG:0]   len,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 busy,
  output logic                 done,
  input  logic [DEPTH_LOG-1:0] addr_rd,
  output logic [WIDTH-1:0]     data_out
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DEPTH_LOG-1:0] r_ptr;
  logic [DEPTH_LOG:0]   r_cnt;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_load;

  assign ready_out = (r_state == ST_WRITE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

  assign w_accept  = ready_out && valid_in;
  assign w_last    = (r_cnt == (DEPTH_LOG+1)'(1));
  // A zero-length request skips WRITE entirely, so pointer/count are only
  // loaded for non-empty bursts.
  assign w_load    = (r_state == ST_IDLE) && start && (len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_accept && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pointer wraps naturally at DEPTH because DEPTH is a power of two and
  // the register is exactly DEPTH_LOG bits wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_ptr <= base_addr;
      r_cnt <= len;
    end else if (w_accept) begin
      r_ptr <= DEPTH_LOG'(r_ptr + 1'b1);
      r_cnt <= (DEPTH_LOG+1)'(r_cnt - 1'b1);
    end
  end

  ram_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept),
    .i_waddr (r_ptr),
    .i_wdata (data_in),
    .i_raddr (addr_rd),
    .o_rdata (data_out)
  );

endmodule
